// File: rtl/uart_rx_fsm_if.sv
// Byte-side bundle of the 8N1 receiver: serial line in, received byte and status strobes out.
`timescale 1ns / 1ps
interface uart_rx_fsm_if;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_busy;

    // master: the receiver itself; slave: whoever drives the line and consumes bytes.
    modport master (
        input  i_rx,
        output o_data,
        output o_valid,
        output o_frame_err,
        output o_busy
    );

    modport slave (
        output i_rx,
        input  o_data,
        input  o_valid,
        input  o_frame_err,
        input  o_busy
    );
endinterface

// File: rtl/uart_rx_fsm.sv
// 8N1 UART receiver: two-flop line synchroniser, start-bit qualification at half a bit,
// mid-bit data sampling, one-cycle valid / frame-error strobes and break hold-off.
`timescale 1ns / 1ps
module uart_rx_fsm #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned CNT_W        = 14
) (
    input  logic          i_clk,
    input  logic          i_reset,
    uart_rx_fsm_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] L_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(CLKS_PER_BIT - 1);

    state_e           r_state;
    logic             r_rx_meta;
    logic             r_rx_s;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_data;
    logic             r_valid;
    logic             r_frame_err;
    logic             r_busy;

    logic w_cnt_half;
    logic w_cnt_last;

    assign w_cnt_half = (r_cnt == L_HALF);
    assign w_cnt_last = (r_cnt == L_LAST);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_rx_meta   <= bus.i_rx;
            r_rx_s      <= r_rx_meta;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_busy  <= 1'b1;
                    end
                end

                // A low that is gone by half a bit is treated as a glitch, not a start bit.
                S_START: begin
                    if (w_cnt_half) begin
                        r_cnt     <= '0;
                        r_bit_idx <= '0;
                        if (!r_rx_s) begin
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_DATA: begin
                    if (w_cnt_last) begin
                        r_shift   <= {r_rx_s, r_shift[7:1]};
                        r_cnt     <= '0;
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_STOP: begin
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                // Hold off until the line idles so a break cannot masquerade as a start bit.
                S_BREAK: begin
                    r_cnt <= '0;
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_data      = r_data;
    assign bus.o_valid     = r_valid;
    assign bus.o_frame_err = r_frame_err;
    assign bus.o_busy      = r_busy;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Self-checking bench for uart_rx_fsm: table of frames plus hand sequences for latency,
// back-to-back spacing, glitch rejection, break hold-off, mid-frame reset and a full byte sweep.
`timescale 1ns / 1ps
module tb_uart_rx_fsm;

    localparam int unsigned CPB   = 16;
    localparam int unsigned CNT_W = 5;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b1;

    uart_rx_fsm_if bus ();

    uart_rx_fsm #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (CNT_W)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        int         p100;       // bit period in hundredths of a clock
        bit         stop_ok;
        int         gap;        // idle cycles after the frame
        bit         exp_err;    // expected strobe: 0 = o_valid, 1 = o_frame_err
    } vec_t;

    exp_t       sb_q[$];
    int         valid_cycs[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         n_valid = 0;
    logic [7:0] exp_last = 8'h00;
    logic       prev_strobe = 1'b0;
    exp_t       mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    always @(posedge i_clk) cyc++;

    // Scoreboard: every strobe must match the oldest pending expectation.
    always @(negedge i_clk) begin
        if (!i_reset && (bus.o_valid || bus.o_frame_err)) begin
            check("strobe_exclusive", 32'(bus.o_valid & bus.o_frame_err), 32'd0);
            check("strobe_not_consecutive", 32'(prev_strobe), 32'd0);
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", 32'({bus.o_valid, bus.o_frame_err}), 32'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("strobe_kind", 32'(bus.o_frame_err), 32'(mon_e.is_err));
                check("rx_data", 32'(bus.o_data), 32'(mon_e.data));
            end
            if (bus.o_valid) begin
                n_valid++;
                valid_cycs.push_back(cyc);
            end
        end
        prev_strobe = !i_reset && (bus.o_valid || bus.o_frame_err);
    end

    task automatic idle(input int n);
        repeat (n) @(negedge i_clk);
    endtask

    // Drives one 8N1 frame starting at the current negedge; bit edges follow p100/100 cycles.
    task automatic send_frame(input logic [7:0] b, input int p100, input bit stop_ok,
                              input bit push, input bit exp_err);
        logic [9:0] bits;
        int         elapsed;
        int         target;
        exp_t       e;
        bits = {stop_ok, b, 1'b0};
        if (push) begin
            e.is_err = exp_err;
            if (!exp_err) exp_last = b;
            e.data = exp_last;
            sb_q.push_back(e);
        end
        elapsed = 0;
        for (int i = 0; i < 10; i++) begin
            bus.i_rx = bits[i];
            target = ((i + 1) * p100) / 100;
            while (elapsed < target) begin
                @(negedge i_clk);
                elapsed++;
            end
        end
        bus.i_rx = 1'b1;
    endtask

    vec_t vecs[8];
    int   start_cyc;
    int   nv0;

    initial begin
        #60000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'h55, 1600, 1'b1, 20, 1'b0};
        vecs[1] = '{8'h00, 1600, 1'b1, 0,  1'b0};
        vecs[2] = '{8'hFF, 1600, 1'b1, 20, 1'b0};
        vecs[3] = '{8'h96, 1664, 1'b1, 20, 1'b0};
        vecs[4] = '{8'h96, 1536, 1'b1, 20, 1'b0};
        vecs[5] = '{8'hA5, 1600, 1'b0, 40, 1'b1};
        vecs[6] = '{8'h3C, 1600, 1'b1, 20, 1'b0};
        vecs[7] = '{8'hE7, 1600, 1'b1, 20, 1'b0};

        bus.i_rx = 1'b1;
        #1;
        check("reset_data", 32'(bus.o_data), 32'd0);
        check("reset_valid", 32'(bus.o_valid), 32'd0);
        check("reset_frame_err", 32'(bus.o_frame_err), 32'd0);
        check("reset_busy", 32'(bus.o_busy), 32'd0);
        idle(4);
        i_reset = 1'b0;
        idle(4);

        // Table-driven frames (a bad stop bit rides the line low through the gap).
        foreach (vecs[i]) begin
            send_frame(vecs[i].data, vecs[i].p100, vecs[i].stop_ok, 1'b1, vecs[i].exp_err);
            if (!vecs[i].stop_ok) bus.i_rx = 1'b0;
            idle(vecs[i].gap);
            bus.i_rx = 1'b1;
            idle(4);
        end
        idle(20);
        check("table_sb_empty", 32'(sb_q.size()), 32'd0);
        check("table_data_hold", 32'(bus.o_data), 32'(exp_last));

        // Latency from start-bit falling edge to o_valid.
        valid_cycs.delete();
        start_cyc = cyc;
        send_frame(8'h5A, 1600, 1'b1, 1'b1, 1'b0);
        idle(20);
        check("latency_count", 32'(valid_cycs.size()), 32'd1);
        if (valid_cycs.size() >= 1)
            check("latency_cycles", 32'(valid_cycs[0] - start_cyc), 32'd155);

        // Back-to-back 0x00 / 0xFF with one stop bit: valid strobes exactly one frame apart.
        valid_cycs.delete();
        send_frame(8'h00, 1600, 1'b1, 1'b1, 1'b0);
        send_frame(8'hFF, 1600, 1'b1, 1'b1, 1'b0);
        idle(20);
        check("b2b_count", 32'(valid_cycs.size()), 32'd2);
        if (valid_cycs.size() >= 2)
            check("b2b_spacing", 32'(valid_cycs[1] - valid_cycs[0]), 32'(10 * CPB));

        // 3-cycle glitch: FSM leaves idle briefly, then returns without any strobe.
        nv0 = n_valid;
        bus.i_rx = 1'b0;
        idle(3);
        check("glitch_busy_seen", 32'(bus.o_busy), 32'd1);
        bus.i_rx = 1'b1;
        idle(30);
        check("glitch_back_idle", 32'(bus.o_busy), 32'd0);
        check("glitch_no_valid", 32'(n_valid - nv0), 32'd0);
        check("glitch_sb_empty", 32'(sb_q.size()), 32'd0);

        // Frame error then 40-cycle break: no restart while low, data held, next byte clean.
        send_frame(8'hA5, 1600, 1'b0, 1'b1, 1'b1);
        bus.i_rx = 1'b0;
        idle(40);
        check("break_busy", 32'(bus.o_busy), 32'd1);
        check("break_data_hold", 32'(bus.o_data), 32'(exp_last));
        check("break_sb_empty", 32'(sb_q.size()), 32'd0);
        bus.i_rx = 1'b1;
        idle(10);
        check("break_released", 32'(bus.o_busy), 32'd0);
        send_frame(8'h3C, 1600, 1'b1, 1'b1, 1'b0);
        idle(20);
        check("after_break_data", 32'(bus.o_data), 32'h3C);

        // Reset during data bit 4 of 0xC3: outputs clear at once, partial byte dropped.
        fork
            send_frame(8'hC3, 1600, 1'b1, 1'b0, 1'b0);
            begin
                idle(16 + 4 * 16 + 8);
                check("pre_reset_busy", 32'(bus.o_busy), 32'd1);
                #3;
                i_reset = 1'b1;
                #1;
                check("async_reset_data", 32'(bus.o_data), 32'd0);
                check("async_reset_busy", 32'(bus.o_busy), 32'd0);
                check("async_reset_valid", 32'(bus.o_valid), 32'd0);
                check("async_reset_ferr", 32'(bus.o_frame_err), 32'd0);
            end
        join
        exp_last = 8'h00;
        idle(5);
        i_reset = 1'b0;
        idle(10);
        nv0 = n_valid;
        send_frame(8'h81, 1600, 1'b1, 1'b1, 1'b0);
        idle(20);
        check("post_reset_one_valid", 32'(n_valid - nv0), 32'd1);
        check("post_reset_data", 32'(bus.o_data), 32'h81);

        // Full byte sweep.
        nv0 = n_valid;
        for (int b = 0; b < 256; b++) begin
            send_frame(8'(b), 1600, 1'b1, 1'b1, 1'b0);
            idle(2);
        end
        idle(20);
        check("sweep_count", 32'(n_valid - nv0), 32'd256);
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
